// File: rtl/des_ip_stage.sv
// DES initial-permutation stage: permutes each incoming block, then queues it
// with its mode tag in a small valid/ready FIFO ahead of the round engine.
module des_ip_stage #(
  parameter int DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_L,
  output logic [31:0] out_R,
  output logic        out_decrypt,
  output logic [15:0] blk_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  // IP table in DES numbering, entry 1 in the top byte.
  localparam logic [511:0] IP_TAB = {
    8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,
    8'd60, 8'd52, 8'd44, 8'd36, 8'd28, 8'd20, 8'd12, 8'd4,
    8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,
    8'd64, 8'd56, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd8,
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,
    8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
    8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7
  };

  logic [63:0] ip_data;

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_ip
      localparam logic [5:0] DST = 6'(63 - gi);
      localparam logic [5:0] SRC = 6'(64 - int'(IP_TAB[511 - 8*gi -: 8]));
      assign ip_data[DST] = in_data[SRC];
    end
  endgenerate

  logic [64:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic [15:0]   blk_cnt_reg, blk_cnt_next;
  logic          in_ready_reg;
  logic          out_valid_reg;
  logic          push;
  logic          pop;

  assign push = in_valid & in_ready_reg;
  assign pop  = out_valid_reg & out_ready;

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    blk_cnt_next = blk_cnt_reg;
    if (push) begin
      wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next  = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
      blk_cnt_next = blk_cnt_reg + 16'd1;
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Handshake flags are recomputed from the next occupancy so they come straight from flops.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      blk_cnt_reg   <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      blk_cnt_reg   <= blk_cnt_next;
      in_ready_reg  <= (count_next < CNT_FULL);
      out_valid_reg <= (count_next != '0);
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {in_decrypt, ip_data};
    end
  end

  assign {out_decrypt, out_L, out_R} = mem[rd_ptr_reg];
  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign blk_cnt   = blk_cnt_reg;

endmodule

// File: tb/tb_des_ip_stage.sv
// Scoreboard bench for des_ip_stage: expected blocks are queued at push time,
// and a monitor undoes IP with an independent FP table on every pop.
module tb_des_ip_stage;

  localparam int DEPTH = 2;

  localparam int FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        in_decrypt = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_L;
  logic [31:0] out_R;
  logic        out_decrypt;
  logic [15:0] blk_cnt;

  des_ip_stage #(.DEPTH(DEPTH)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_decrypt  (in_decrypt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_L       (out_L),
    .out_R       (out_R),
    .out_decrypt (out_decrypt),
    .blk_cnt     (blk_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [63:0] raw;
    logic        tag;
    logic        has_ip;
    logic [63:0] ip;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   pops = 0;
  int   stalls = 0;
  bit   rand_mode = 1'b0;
  bit   quiet = 1'b0;

  function automatic logic [63:0] fp(input logic [63:0] y);
    logic [63:0] x;
    x = '0;
    for (int i = 0; i < 64; i++) begin
      if (((y >> (64 - FP_TAB[i])) & 64'd1) != 64'd0) x = x | (64'd1 << (63 - i));
    end
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens on the coming edge whenever valid and ready are both high here.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_block: got %h%h expected no block", out_L, out_R);
      end else begin
        e = sb_q.pop_front();
        chk("roundtrip", fp({out_L, out_R}), e.raw);
        chk("tag", 64'(out_decrypt), 64'(e.tag));
        if (e.has_ip) chk("ip_value", {out_L, out_R}, e.ip);
        if (!quiet) $display("pop: L=%h R=%h tag=%0d raw=%h", out_L, out_R, out_decrypt, e.raw);
      end
      pops++;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [63:0] d, input logic t, input logic hip, input logic [63:0] ipv);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_decrypt = t;
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    while (!in_ready) begin
      if (n >= 200) begin
        checks++;
        errors++;
        $display("FAIL push_timeout: got in_ready=0 for %0d cycles expected 1", n);
        in_valid = 1'b0;
        return;
      end
      n++;
      stalls++;
      @(posedge Clk);
      #1;
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    end
    sb_q.push_back('{d, t, hip, ipv});
    if (!quiet) $display("push: data=%h tag=%0d", d, t);
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge Clk);
      #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d blocks pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    #1 Reset_n = 1'b0;
    #11;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_blk_cnt", 64'(blk_cnt), 64'd0);
    @(posedge Clk);
    #1 Reset_n = 1'b1;

    // Known-answer vector, first edge after reset release takes the push.
    out_ready = 1'b1;
    stalls = 0;
    send(64'h0123456789ABCDEF, 1'b0, 1'b1, 64'hCC00CCFFF0AAF0AA);
    chk("first_edge_push", 64'(stalls), 64'd0);
    chk("latency_out_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    @(posedge Clk);
    #1;
    chk("blk_cnt_after_pop", 64'(blk_cnt), 64'd1);
    chk("empty_after_pop", 64'(out_valid), 64'd0);

    // Single-bit and corner vectors with hand-derived IP images.
    send(64'h0000000000000000, 1'b1, 1'b1, 64'h0000000000000000);
    send(64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFF);
    send(64'h8000000000000000, 1'b1, 1'b1, 64'h0000000001000000);
    send(64'h0000000000000001, 1'b0, 1'b1, 64'h0000008000000000);
    drain();
    chk("blk_cnt_vectors", 64'(blk_cnt), 64'd5);

    // Backpressure: fill, hold, single pop frees one slot.
    out_ready = 1'b0;
    send(64'h0123456789ABCDEF, 1'b1, 1'b1, 64'hCC00CCFFF0AAF0AA);
    send(64'h8000000000000000, 1'b0, 1'b1, 64'h0000000001000000);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_data = 64'h0000000000000001;
    in_decrypt = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("hold_data", {out_L, out_R}, 64'hCC00CCFFF0AAF0AA);
    chk("hold_tag", 64'(out_decrypt), 64'd1);
    chk("full_stays_blocked", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(posedge Clk);
    #1 out_ready = 1'b0;
    chk("in_ready_after_pop", 64'(in_ready), 64'd1);
    send(64'h0000000000000001, 1'b1, 1'b1, 64'h0000008000000000);
    chk("refull_in_ready", 64'(in_ready), 64'd0);
    drain();
    chk("blk_cnt_backpressure", 64'(blk_cnt), 64'd8);

    // Continuous streaming: no stalls, one pop per cycle.
    quiet = 1'b1;
    out_ready = 1'b1;
    stalls = 0;
    p0 = pops;
    for (int i = 0; i < 100; i++) send({$urandom, $urandom}, 1'($urandom), 1'b0, '0);
    drain();
    chk("stream_stalls", 64'(stalls), 64'd0);
    chk("stream_pops", 64'(pops - p0), 64'd100);
    chk("blk_cnt_stream", 64'(blk_cnt), 64'd108);

    // Random round trip under random backpressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) send({$urandom, $urandom}, 1'($urandom), 1'b0, '0);
    rand_mode = 1'b0;
    drain();
    chk("blk_cnt_random", 64'(blk_cnt), 64'd1108);
    quiet = 1'b0;

    // Reset pulse between edges with a full buffer.
    out_ready = 1'b0;
    send(64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF);
    send(64'h0000000000000000, 1'b1, 1'b1, 64'h0000000000000000);
    in_valid = 1'b0;
    chk("prereset_full", 64'(in_ready), 64'd0);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd1);
    chk("async_blk_cnt", 64'(blk_cnt), 64'd0);
    sb_q.delete();
    #4 Reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    chk("no_stale_block", 64'(out_valid), 64'd0);
    send(64'h0123456789ABCDEF, 1'b0, 1'b1, 64'hCC00CCFFF0AAF0AA);
    drain();
    chk("blk_cnt_post_reset", 64'(blk_cnt), 64'd1);

    // Counter wrap: reach 0xFFFF, then one more pop.
    quiet = 1'b1;
    for (int i = 0; i < 65534; i++) send({$urandom, $urandom}, 1'($urandom), 1'b0, '0);
    drain();
    chk("blk_cnt_max", 64'(blk_cnt), 64'hFFFF);
    quiet = 1'b0;
    send(64'h8000000000000000, 1'b1, 1'b1, 64'h0000000001000000);
    drain();
    chk("blk_cnt_wrap", 64'(blk_cnt), 64'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
